// File: rtl/axi_slave_pkg.sv
//==============================================================================
// Module      : axi_slave_pkg
// Description : Shared types and burst-address helper for the AXI slave
//               write and read controllers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package axi_slave_pkg;

    // Internal width used for address arithmetic; wide enough for any ADDR_LEN
    // the controllers are built with, results are truncated by the caller.
    localparam int ADDR_CALC_W = 64;

    typedef enum logic [1:0] {
        FIXED = 2'b00,
        INCR  = 2'b01,
        WRAP  = 2'b10,
        RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        DATA = 2'b01,
        RESP = 2'b10
    } wr_state_e;

    // Address of the beat following 'addr' within a burst that began at 'start'.
    // INCR and WRAP step from the size-aligned current address, so an unaligned
    // start only affects beat 0. WRAP folds back to the span-aligned base.
    function automatic logic [ADDR_CALC_W-1:0] next_beat_addr(
        input logic [ADDR_CALC_W-1:0] addr,
        input logic [2:0]             size,
        input logic [7:0]             len,
        input burst_e                 burst,
        input logic [ADDR_CALC_W-1:0] start
    );
        logic [ADDR_CALC_W-1:0] bytes;
        logic [ADDR_CALC_W-1:0] span;
        logic [ADDR_CALC_W-1:0] low;
        logic [ADDR_CALC_W-1:0] step;
        bytes = {{(ADDR_CALC_W-1){1'b0}}, 1'b1} << size;
        span  = ({{(ADDR_CALC_W-8){1'b0}}, len} + 1) << size;
        low   = start & ~(span - 1);
        step  = (addr & ~(bytes - 1)) + bytes;
        case (burst)
            FIXED:   next_beat_addr = addr;
            WRAP:    next_beat_addr = (step == low + span) ? low : step;
            default: next_beat_addr = step;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/axi_burst_addr_gen.sv
//==============================================================================
// Module      : axi_burst_addr_gen
// Description : Combinational next-beat address generator for FIXED, INCR and
//               WRAP bursts. Shared by the write and read controllers.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_burst_addr_gen
    import axi_slave_pkg::*;
#(
    parameter int ADDR_LEN = 32
) (
    input  logic [ADDR_LEN-1:0] addr,
    input  logic [ADDR_LEN-1:0] start,
    input  logic [2:0]          size,
    input  logic [7:0]          len,
    input  logic [1:0]          burst,
    output logic [ADDR_LEN-1:0] next_addr
);

    // Step the current beat address; INCR wraps modulo 2^ADDR_LEN by truncation.
    always_comb begin
        next_addr = ADDR_LEN'(next_beat_addr(ADDR_CALC_W'(addr), size, len,
                                             burst_e'(burst), ADDR_CALC_W'(start)));
    end

endmodule

`default_nettype wire

// File: rtl/axi_slave_wr_ctrl.sv
//==============================================================================
// Module      : axi_slave_wr_ctrl
// Description : AXI4 slave write-path controller. Accepts one burst at a time,
//               turns each W beat into a byte-strobed memory write and returns
//               one B response per burst.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module axi_slave_wr_ctrl
    import axi_slave_pkg::*;
#(
    parameter int NUM_ID   = 4,
    parameter int DATA_LEN = 32,
    parameter int ADDR_LEN = 32
) (
    input  logic                    ACLK,
    input  logic                    ARESETn,
    input  logic                    AWVALID,
    output logic                    AWREADY,
    input  logic [NUM_ID-1:0]       AWID,
    input  logic [ADDR_LEN-1:0]     AWADDR,
    input  logic [7:0]              AWLEN,
    input  logic [2:0]              AWSIZE,
    input  logic [1:0]              AWBURST,
    input  logic                    WVALID,
    output logic                    WREADY,
    input  logic [DATA_LEN-1:0]     WDATA,
    input  logic [DATA_LEN/8-1:0]   WSTRB,
    input  logic                    WLAST,
    output logic                    BVALID,
    input  logic                    BREADY,
    output logic [NUM_ID-1:0]       BID,
    output logic [1:0]              BRESP,
    output logic                    mem_we,
    output logic [ADDR_LEN-1:0]     mem_addr,
    output logic [DATA_LEN-1:0]     mem_wdata,
    output logic [DATA_LEN/8-1:0]   mem_wstrb
);

    localparam int STRB_LEN = DATA_LEN / 8;
    localparam int MAX_SIZE = $clog2(STRB_LEN);
    localparam logic [ADDR_LEN-1:0] ALIGN_MASK = ~ADDR_LEN'(STRB_LEN - 1);

    wr_state_e             state;
    wr_state_e             next_state;

    logic [NUM_ID-1:0]     id_q;
    logic [ADDR_LEN-1:0]   start_q;
    logic [ADDR_LEN-1:0]   beat_addr;
    logic [ADDR_LEN-1:0]   next_addr;
    logic [7:0]            len_q;
    logic [2:0]            size_q;
    logic [1:0]            burst_q;
    logic [7:0]            beat_cnt;
    logic                  cfg_err;
    logic                  wlast_err;

    logic                  aw_hs;
    logic                  w_hs;
    logic                  b_hs;
    logic                  final_beat;
    logic                  wlast_bad;
    logic                  aw_cfg_err;
    logic                  awready_d;
    logic                  wready_d;
    logic                  bvalid_d;

    assign aw_hs      = AWVALID & AWREADY;
    assign w_hs       = WVALID & WREADY;
    assign b_hs       = BVALID & BREADY;
    assign final_beat = (beat_cnt == len_q);
    // WLAST must be high on exactly the beat the counter says is final.
    assign wlast_bad  = (final_beat != WLAST);

    // Next-beat address from the shared generator.
    axi_burst_addr_gen #(
        .ADDR_LEN (ADDR_LEN)
    ) u_addr_gen (
        .addr      (beat_addr),
        .start     (start_q),
        .size      (size_q),
        .len       (len_q),
        .burst     (burst_q),
        .next_addr (next_addr)
    );

    // Classify the presented AW request; an illegal one is still consumed but
    // every write in the burst is suppressed and the response is SLVERR.
    always_comb begin
        aw_cfg_err = 1'b0;
        if (int'(AWSIZE) > MAX_SIZE) begin
            aw_cfg_err = 1'b1;
        end
        if (AWBURST == RSVD) begin
            aw_cfg_err = 1'b1;
        end
        if (AWBURST == WRAP) begin
            if (!(AWLEN == 8'd1 || AWLEN == 8'd3 || AWLEN == 8'd7 || AWLEN == 8'd15)) begin
                aw_cfg_err = 1'b1;
            end
            if ((AWADDR[6:0] & ((7'd1 << AWSIZE) - 7'd1)) != 7'd0) begin
                aw_cfg_err = 1'b1;
            end
        end
    end

    // State register plus the registered handshake outputs.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state   <= IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
        end else begin
            state   <= next_state;
            AWREADY <= awready_d;
            WREADY  <= wready_d;
            BVALID  <= bvalid_d;
        end
    end

    // Next-state logic: the beat counter, not WLAST, ends the data phase.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (aw_hs)              next_state = DATA;
            DATA:    if (w_hs && final_beat) next_state = RESP;
            RESP:    if (b_hs)               next_state = IDLE;
            default:                         next_state = IDLE;
        endcase
    end

    // Ready/valid flags are registered from the upcoming state so they are
    // glitch-free and drop in the cycle after the closing handshake.
    always_comb begin
        awready_d = (next_state == IDLE);
        wready_d  = (next_state == DATA);
        bvalid_d  = (next_state == RESP);
    end

    // Burst context, beat counter and sticky error flags.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            id_q      <= '0;
            start_q   <= '0;
            beat_addr <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            beat_cnt  <= '0;
            cfg_err   <= 1'b0;
            wlast_err <= 1'b0;
        end else if (aw_hs) begin
            id_q      <= AWID;
            start_q   <= AWADDR;
            beat_addr <= AWADDR;
            len_q     <= AWLEN;
            size_q    <= AWSIZE;
            burst_q   <= AWBURST;
            beat_cnt  <= '0;
            cfg_err   <= aw_cfg_err;
            wlast_err <= 1'b0;
        end else if (w_hs) begin
            beat_cnt  <= beat_cnt + 8'd1;
            beat_addr <= next_addr;
            if (wlast_bad) begin
                wlast_err <= 1'b1;
            end
        end else if (b_hs) begin
            cfg_err   <= 1'b0;
            wlast_err <= 1'b0;
        end
    end

    // Memory write port: one registered write per accepted beat.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else begin
            mem_we <= w_hs;
            if (w_hs) begin
                mem_addr  <= beat_addr & ALIGN_MASK;
                mem_wdata <= WDATA;
                mem_wstrb <= cfg_err ? '0 : WSTRB;
            end
        end
    end

    // Response fields are loaded on the final beat and held through RESP.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            BID   <= '0;
            BRESP <= '0;
        end else if (w_hs && final_beat) begin
            BID   <= id_q;
            BRESP <= (cfg_err || wlast_err || wlast_bad) ? SLVERR : OKAY;
        end
    end

endmodule

`default_nettype wire
